// File: rtl/sig_norm_round_if.sv
// Stream bundle for sig_norm_round: the input product beat and the rounded result,
// each with its own valid/ready handshake.
interface sig_norm_round_if #(
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 5,
  parameter int PROD_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PROD_W-1:0]       prod;
  logic signed [7:0]       exp_in;
  logic                    sign_in;
  logic                    zero_in;

  logic                    out_valid;
  logic                    out_ready;
  logic [FRAC_W-1:0]       frac_out;
  logic [EXP_W-1:0]        exp_out;
  logic                    sign_out;
  logic                    ovf;
  logic                    unf;
  logic                    inexact;

  modport master (
    output in_valid, prod, exp_in, sign_in, zero_in, out_ready,
    input  in_ready, out_valid, frac_out, exp_out, sign_out, ovf, unf, inexact
  );

  modport slave (
    input  in_valid, prod, exp_in, sign_in, zero_in, out_ready,
    output in_ready, out_valid, frac_out, exp_out, sign_out, ovf, unf, inexact
  );
endinterface

// File: rtl/sig_norm_round.sv
// FP16 significand normalize + round stage (2-deep pipeline, valid/ready).
// Define SIG_NORM_ROUND_RTZ_EN to round toward zero instead of nearest-even.
module sig_norm_round #(
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 5,
  parameter int PROD_W = 24
) (
  input logic            clk,
  input logic            rst_n,
  sig_norm_round_if.slave bus
);

  localparam logic signed [8:0] E_MAX = 9'((1 << EXP_W) - 1);

  logic                    s1_valid;
  logic [FRAC_W-1:0]       s1_f;
  logic                    s1_g;
  logic                    s1_s;
  logic signed [8:0]       s1_e;
  logic                    s1_sign;
  logic                    s1_zero;

  logic                    s2_valid;
  logic [FRAC_W-1:0]       res_frac;
  logic [EXP_W-1:0]        res_exp;
  logic                    res_sign;
  logic                    res_ovf;
  logic                    res_unf;
  logic                    res_inexact;

  logic                    s2_load;
  logic                    s1_load;

  logic [FRAC_W-1:0]       n_f;
  logic                    n_g;
  logic                    n_s;
  logic signed [8:0]       n_e;

  logic                    rnd_up;
  logic [FRAC_W:0]         r_sum;
  logic signed [8:0]       r_e;
  logic                    r_inexact;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = !(s1_valid && s2_valid && !bus.out_ready);

  // A product in [2,4) has its leading one at bit 2*FRAC_W+1 and needs one right shift.
  always_comb begin
    n_e = {bus.exp_in[7], bus.exp_in};
    if (bus.prod[2*FRAC_W+1]) begin
      n_f = bus.prod[2*FRAC_W:FRAC_W+1];
      n_g = bus.prod[FRAC_W];
      n_s = |bus.prod[FRAC_W-1:0];
      n_e = n_e + 9'sd1;
    end else begin
      n_f = bus.prod[2*FRAC_W-1:FRAC_W];
      n_g = bus.prod[FRAC_W-1];
      n_s = |bus.prod[FRAC_W-2:0];
    end
  end

  always_comb begin
`ifdef SIG_NORM_ROUND_RTZ_EN
    rnd_up = 1'b0;
`else
    rnd_up = s1_g && (s1_s || s1_f[0]);
`endif
    r_sum     = {1'b0, s1_f} + {{FRAC_W{1'b0}}, rnd_up};
    r_e       = s1_e + (r_sum[FRAC_W] ? 9'sd1 : 9'sd0);
    r_inexact = s1_g || s1_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_e     <= '0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_f    <= n_f;
        s1_g    <= n_g;
        s1_s    <= n_s;
        s1_e    <= n_e;
        s1_sign <= bus.sign_in;
        s1_zero <= bus.zero_in;
      end
    end
  end

  // Zero operands win over range checks; overflow saturates to infinity, underflow flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      res_frac    <= '0;
      res_exp     <= '0;
      res_sign    <= 1'b0;
      res_ovf     <= 1'b0;
      res_unf     <= 1'b0;
      res_inexact <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        res_sign <= s1_sign;
        if (s1_zero) begin
          res_frac    <= '0;
          res_exp     <= '0;
          res_ovf     <= 1'b0;
          res_unf     <= 1'b0;
          res_inexact <= 1'b0;
        end else if (r_e >= E_MAX) begin
          res_frac    <= '0;
          res_exp     <= '1;
          res_ovf     <= 1'b1;
          res_unf     <= 1'b0;
          res_inexact <= 1'b1;
        end else if (r_e <= 9'sd0) begin
          res_frac    <= '0;
          res_exp     <= '0;
          res_ovf     <= 1'b0;
          res_unf     <= 1'b1;
          res_inexact <= 1'b1;
        end else begin
          res_frac    <= r_sum[FRAC_W-1:0];
          res_exp     <= r_e[EXP_W-1:0];
          res_ovf     <= 1'b0;
          res_unf     <= 1'b0;
          res_inexact <= r_inexact;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.frac_out  = res_frac;
  assign bus.exp_out   = res_exp;
  assign bus.sign_out  = res_sign;
  assign bus.ovf       = res_ovf;
  assign bus.unf       = res_unf;
  assign bus.inexact   = res_inexact;

endmodule

// File: doc/sig_norm_round.md
Name: sig_norm_round

Overview:
- Downstream neighbour of booth_multiplier in the FP16 significand-multiply path.
- Consumes the 24-bit significand product together with the sign, exponent-sum and zero flag from the exponent path.
- Normalizes the product, applies round-to-nearest-even, adjusts the exponent and detects overflow/underflow.
- Two-stage pipeline with valid/ready handshake; results feed the FP16 result packer.

Parameters:
- FRAC_W, 10, stored fraction width.
- EXP_W, 5, biased exponent width; all-ones encodes infinity.
- PROD_W, 24, product input width; bits [23:22] ignored.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- prod  input  24  significand product 1.x*1.x; binary point between bits 20 and 19; value in [1,4).
- exp_in  input  8  signed biased exponent candidate ea+eb-15, range -15..45.
- sign_in  input  1  result sign (sa^sb).
- zero_in  input  1  either operand zero (azero|bzero).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- frac_out  output  10  rounded fraction.
- exp_out  output  5  biased exponent.
- sign_out  output  1  sign.
- ovf  output  1  overflow; result forced to infinity.
- unf  output  1  underflow; result flushed to zero.
- inexact  output  1  rounding discarded nonzero bits.

Behaviour:
- Reset:
  - All outputs and pipeline registers clear to 0.
  - Both stage-valid bits clear, so out_valid=0.
  - in_ready=1 from the first CLK edge after RST deasserts.
- Handshake:
  - Input transfer occurs on in_valid&in_ready; output transfer on out_valid&out_ready.
  - in_ready = !(s1_valid & s2_valid & !out_ready).
  - Stage 2 loads from stage 1 when s2 is empty or out_ready=1.
  - Stage 1 loads when its contents move on or it is empty.
  - No beat dropped or duplicated; order preserved.
  - Outputs hold stable while out_valid&!out_ready.
- Latency: 2 cycles from an accepted input to out_valid with no stall; throughput 1 beat/cycle.
- Stage 1, normalize:
  - If prod[21]=1: f=prod[20:11], g=prod[10], s=|prod[9:0], e=exp_in+1.
  - Else: f=prod[19:10], g=prod[9], s=|prod[8:0], e=exp_in.
  - prod[20] is assumed 1 when prod[21]=0; no further left-shift is performed.
- Stage 2, round:
  - Round up when g&(s|f[0]).
  - If f=0x3FF and round up: f=0, e=e+1.
  - inexact=g|s.
- Range check on the final e (signed, 9-bit internal):
  - e>=31: ovf=1, exp_out=31, frac_out=0, inexact=1.
  - e<=0: unf=1, exp_out=0, frac_out=0, inexact=1. No subnormals.
- zero_in=1 overrides everything: exp_out=0, frac_out=0, ovf=unf=inexact=0; sign_out still = sign_in.
- sign_out always passes through.
- Flags are per-beat, valid only with out_valid; not sticky.
- RST asserted mid-operation clears both stages immediately; in-flight beats are discarded and out_valid drops asynchronously.

Optional Feature:
- Macro SIG_NORM_ROUND_RTZ_EN.
- Defined: round-toward-zero. Never round up; carry path unused; inexact=g|s still reported; overflow/underflow rules unchanged.
- Undefined: round-to-nearest-even as above.

Test Plan:
- 1.0*1.0, prod=0x100000, exp_in=15, zero_in=0 -> frac_out=0x000, exp_out=15, all flags 0, out_valid 2 cycles after accept.
- 1.5*1.5, prod=0x240000, exp_in=15 -> frac_out=0x080, exp_out=16, inexact=0.
- Tie-to-even with carry, prod=0x1FFE00, exp_in=14 -> frac_out=0x000, exp_out=15, inexact=1. With SIG_NORM_ROUND_RTZ_EN: frac_out=0x3FF, exp_out=14, inexact=1.
- Range and zero cases:
  - prod=0x200000, exp_in=30 -> ovf=1, exp_out=31, frac_out=0.
  - prod=0x100000, exp_in=0 -> unf=1, exp_out=0, frac_out=0.
  - zero_in=1 with any prod -> all-zero result, flags 0.
- Backpressure:
  - Stimulus: 4 back-to-back beats; out_ready=0 for 6 cycles, then 1.
  - in_ready=0 once both stages hold beats.
  - out_valid and outputs stable during the stall; all 4 results emerge in order with no loss.
- Reset mid-stream: 2 beats in flight, RST=0 for 1 cycle -> out_valid=0 immediately, no stale beat afterwards, in_ready=1 after release.
